// File: rtl/regfile_seq_pkg.sv
// Shared constants for the tile register-file command sequencer:
// opcodes, regfile op codes, the "no register" select and the FSM encoding.
package regfile_seq_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_XCOPY = 2'b11;

    localparam logic [1:0] RF_OP_NORMAL    = 2'b00;
    localparam logic [1:0] RF_OP_TRANSPOSE = 2'b11;

    localparam int SEL_NONE = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_STORE = 3'd2,
        ST_COPY  = 3'd3,
        ST_ERR   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // A command is legal when every register it names is real and a copy never targets its own source.
    function automatic logic cmd_legal(input logic [1:0] op, input logic src_none,
                                       input logic dst_none, input logic same);
        logic ok;
        case (op)
            OP_LOAD:  ok = !dst_none;
            OP_STORE: ok = !src_none;
            default:  ok = !src_none && !dst_none && !same;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/regfile_seq.sv
// Tile command sequencer: accepts one LOAD/STORE/COPY/XCOPY command and streams
// its row beats by driving the regfile op and select lines.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int ROWS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [SEL_W-1:0] cmd_src,
    input  logic [SEL_W-1:0] cmd_dst,
    input  logic             ld_valid,
    output logic             ld_ready,
    output logic             st_valid,
    input  logic             st_ready,
    output logic [1:0]       rf_op,
    output logic [SEL_W-1:0] rf_sel_in_1,
    output logic [SEL_W-1:0] rf_sel_in_3,
    output logic [SEL_W-1:0] rf_sel_out_1,
    output logic [SEL_W-1:0] rf_sel_out_3,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int                CNT_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(ROWS - 1);
    localparam logic [SEL_W-1:0]  SEL_ZERO = SEL_W'(SEL_NONE);

    state_e             r_state;
    state_e             w_next;
    logic [1:0]         r_op;
    logic [SEL_W-1:0]   r_src;
    logic [SEL_W-1:0]   r_dst;
    logic [CNT_W-1:0]   r_row;
    logic               r_err;
    logic               r_done;
    logic               r_busy;
    logic               r_cmd_ready;
    logic               r_ld_ready;
    logic               r_st_valid;
    logic               w_accept;
    logic               w_legal;
    logic               w_beat;
    logic               w_last;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);
    assign w_legal  = cmd_legal(cmd_op, cmd_src == SEL_ZERO, cmd_dst == SEL_ZERO, cmd_src == cmd_dst);
    assign w_last   = w_beat && (r_row == LAST_ROW);

    assign cmd_ready = r_cmd_ready;
    assign ld_ready  = r_ld_ready;
    assign st_valid  = r_st_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

    // Beat qualification: external handshake for LOAD/STORE, free-running for COPY.
    always_comb begin
        w_beat = 1'b0;
        case (r_state)
            ST_LOAD:  w_beat = ld_valid;
            ST_STORE: w_beat = st_ready;
            ST_COPY:  w_beat = 1'b1;
            default:  w_beat = 1'b0;
        endcase
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_accept) begin
                    w_next = ST_IDLE;
                end else if (!w_legal) begin
                    w_next = ST_ERR;
                end else if (cmd_op == OP_LOAD) begin
                    w_next = ST_LOAD;
                end else if (cmd_op == OP_STORE) begin
                    w_next = ST_STORE;
                end else begin
                    w_next = ST_COPY;
                end
            end
            ST_LOAD, ST_STORE, ST_COPY: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = r_state;
                end
            end
            ST_ERR:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM state, command capture, row counter and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LOAD;
            r_src       <= SEL_ZERO;
            r_dst       <= SEL_ZERO;
            r_row       <= {CNT_W{1'b0}};
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_ld_ready  <= 1'b0;
            r_st_valid  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op  <= cmd_op;
                r_src <= cmd_src;
                r_dst <= cmd_dst;
                r_row <= {CNT_W{1'b0}};
                r_err <= 1'b0;
            end else if (w_beat) begin
                r_row <= w_last ? {CNT_W{1'b0}} : r_row + CNT_W'(1);
            end else if (r_state == ST_ERR) begin
                r_err <= 1'b1;
            end else begin
                r_row <= r_row;
            end
            r_done      <= (w_next == ST_DONE);
            r_busy      <= (w_next != ST_IDLE);
            r_cmd_ready <= (w_next == ST_IDLE);
            r_ld_ready  <= (w_next == ST_LOAD);
            r_st_valid  <= (w_next == ST_STORE);
        end
    end

    // Regfile selects: only the path owned by the current state is ever nonzero, and stalls gate it.
    always_comb begin
        rf_op        = RF_OP_NORMAL;
        rf_sel_in_1  = SEL_ZERO;
        rf_sel_in_3  = SEL_ZERO;
        rf_sel_out_1 = SEL_ZERO;
        rf_sel_out_3 = SEL_ZERO;
        case (r_state)
            ST_LOAD: begin
                if (ld_valid) begin
                    rf_sel_in_3 = r_dst;
                end else begin
                    rf_sel_in_3 = SEL_ZERO;
                end
            end
            ST_STORE: begin
                if (st_ready) begin
                    rf_sel_out_3 = r_src;
                end else begin
                    rf_sel_out_3 = SEL_ZERO;
                end
            end
            ST_COPY: begin
                rf_sel_out_1 = r_src;
                rf_sel_in_1  = r_dst;
                rf_op        = (r_op == OP_XCOPY) ? RF_OP_TRANSPOSE : RF_OP_NORMAL;
            end
            default: rf_op = RF_OP_NORMAL;
        endcase
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: a behavioural 4x4 tile regfile follows the DUT selects,
// a command table plus hand sequences cover stalls, illegal commands and reset.
module tb_regfile_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_src;
    logic [3:0] cmd_dst;
    logic       ld_valid;
    logic       ld_ready;
    logic       st_valid;
    logic       st_ready;
    logic [1:0] rf_op;
    logic [3:0] rf_sel_in_1;
    logic [3:0] rf_sel_in_3;
    logic [3:0] rf_sel_out_1;
    logic [3:0] rf_sel_out_3;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    regfile_seq #(.SEL_W(4), .ROWS(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .st_valid(st_valid), .st_ready(st_ready),
        .rf_op(rf_op),
        .rf_sel_in_1(rf_sel_in_1), .rf_sel_in_3(rf_sel_in_3),
        .rf_sel_out_1(rf_sel_out_1), .rf_sel_out_3(rf_sel_out_3),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row k of the load stream: lane i holds 4*i+k+1, so row 0 is {13,9,5,1}.
    function automatic logic [63:0] load_row(input int k);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = 16'(4*i + k + 1);
        return r;
    endfunction

    // Row k of the transposed tile: lane i holds 4*k+i+1, so row 0 is {4,3,2,1}.
    function automatic logic [63:0] trans_row(input int k);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = 16'(4*k + i + 1);
        return r;
    endfunction

    // Behavioural tile regfile with per-path row pointers.
    logic [63:0] m_rf [16][4];
    logic [1:0]  m_ld_cnt;
    logic [1:0]  m_st_cnt;
    logic [1:0]  m_cp_cnt;
    logic [63:0] ld_data;
    logic [63:0] st_data;
    logic [63:0] cp_row;

    assign ld_data = load_row(int'(m_ld_cnt));
    assign st_data = m_rf[rf_sel_out_3][m_st_cnt];

    always_comb begin
        cp_row = m_rf[rf_sel_out_1][m_cp_cnt];
        if (rf_op == 2'b11) begin
            for (int i = 0; i < 4; i++)
                cp_row[16*i +: 16] = m_rf[rf_sel_out_1][i[1:0]][16*int'(m_cp_cnt) +: 16];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ld_cnt <= 2'd0;
            m_st_cnt <= 2'd0;
            m_cp_cnt <= 2'd0;
        end else begin
            if (rf_sel_in_3 != 4'd0) begin
                m_rf[rf_sel_in_3][m_ld_cnt] <= ld_data;
                m_ld_cnt <= m_ld_cnt + 2'd1;
            end
            if (rf_sel_out_3 != 4'd0) m_st_cnt <= m_st_cnt + 2'd1;
            if (rf_sel_in_1 != 4'd0) begin
                m_rf[rf_sel_in_1][m_cp_cnt] <= cp_row;
                m_cp_cnt <= m_cp_cnt + 2'd1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one command and follow it to done, checking every cycle's select/status pattern.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] src,
                           input logic [3:0] dst, input logic exp_err, input int exp_lat,
                           input logic [7:0] ld_pat, input logic [7:0] st_pat, input int dat_kind);
        int          lat = 0;
        int          beats = 0;
        int          sel_bad = 0;
        int          j = 0;
        bit          fin = 1'b0;
        logic        err_seen = 1'b0;
        logic [63:0] rows[$];
        logic [3:0]  e_in1, e_in3, e_out1, e_out3;
        logic [1:0]  e_op;
        logic        e_ld, e_st;
        logic [63:0] exp_row;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst;
        ld_valid = 1'b0; st_ready = 1'b0;
        #1 chk({tag, ".ready"}, int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!fin && j < 40) begin
            ld_valid = (j < 8) ? ld_pat[j[2:0]] : 1'b1;
            st_ready = (j < 8) ? st_pat[j[2:0]] : 1'b1;
            #1;
            if (done) begin
                fin = 1'b1;
                lat = j + 1;
                err_seen = err;
                if ({rf_sel_in_1, rf_sel_in_3, rf_sel_out_1, rf_sel_out_3, rf_op,
                     ld_ready, st_valid, busy, cmd_ready} !== {16'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0})
                    sel_bad++;
            end else begin
                e_in1 = 4'd0; e_in3 = 4'd0; e_out1 = 4'd0; e_out3 = 4'd0;
                e_op = 2'b00; e_ld = 1'b0; e_st = 1'b0;
                if (!exp_err) begin
                    case (op)
                        2'b00: begin e_in3 = ld_valid ? dst : 4'd0; e_ld = 1'b1; end
                        2'b01: begin e_out3 = st_ready ? src : 4'd0; e_st = 1'b1; end
                        default: begin
                            e_in1 = dst; e_out1 = src;
                            e_op = (op == 2'b11) ? 2'b11 : 2'b00;
                        end
                    endcase
                end
                if ({rf_sel_in_1, rf_sel_in_3, rf_sel_out_1, rf_sel_out_3, rf_op,
                     ld_ready, st_valid, busy, cmd_ready} !==
                    {e_in1, e_in3, e_out1, e_out3, e_op, e_ld, e_st, 1'b1, 1'b0})
                    sel_bad++;
                if ((rf_sel_in_1 | rf_sel_in_3 | rf_sel_out_3) != 4'd0) beats++;
                if (rf_sel_out_3 != 4'd0) rows.push_back(st_data);
                @(negedge clk);
                j++;
            end
        end
        ld_valid = 1'b0;
        st_ready = 1'b0;
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".err"}, int'(err_seen), int'(exp_err));
        chk({tag, ".sel"}, sel_bad, 0);
        chk({tag, ".beats"}, beats, exp_err ? 0 : 4);
        if (dat_kind != 0) begin
            chk({tag, ".nrows"}, rows.size(), 4);
            for (int k = 0; k < 4; k++) begin
                exp_row = (dat_kind == 1) ? load_row(k) : trans_row(k);
                chk64($sformatf("%s.row%0d", tag, k), (k < rows.size()) ? rows[k] : 64'd0, exp_row);
            end
        end
        @(negedge clk);
        #1 chk({tag, ".idle"}, int'({busy, cmd_ready, done}), 3'b010);
    endtask

    typedef struct {
        string      tag;
        logic [1:0] op;
        logic [3:0] src;
        logic [3:0] dst;
        logic       exp_err;
        int         exp_lat;
        int         dat_kind;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"load1",     2'b00, 4'd0, 4'd1, 1'b0, 5, 0};
        vecs[1] = '{"store1",    2'b01, 4'd1, 4'd0, 1'b0, 5, 1};
        vecs[2] = '{"xcopy13",   2'b11, 4'd1, 4'd3, 1'b0, 5, 0};
        vecs[3] = '{"store3",    2'b01, 4'd3, 4'd0, 1'b0, 5, 2};
        vecs[4] = '{"copy22",    2'b10, 4'd2, 4'd2, 1'b1, 2, 0};
        vecs[5] = '{"copy12",    2'b10, 4'd1, 4'd2, 1'b0, 5, 0};
        vecs[6] = '{"load0",     2'b00, 4'd0, 4'd0, 1'b1, 2, 0};
        vecs[7] = '{"store0",    2'b01, 4'd0, 4'd0, 1'b1, 2, 0};
        vecs[8] = '{"xcopy03",   2'b11, 4'd0, 4'd3, 1'b1, 2, 0};
        vecs[9] = '{"load5",     2'b00, 4'd0, 4'd5, 1'b0, 5, 0};

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 4'd0; cmd_dst = 4'd0;
        ld_valid = 1'b0; st_ready = 1'b0;
        #3;
        chk("reset.outs", int'({busy, done, err, ld_ready, st_valid, rf_op,
                                rf_sel_in_1, rf_sel_in_3, rf_sel_out_1, rf_sel_out_3}), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1 chk("reset.ready", int'(cmd_ready), 1);

        for (int v = 0; v < 10; v++)
            run_cmd(vecs[v].tag, vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].exp_err,
                    vecs[v].exp_lat, 8'hFF, 8'hFF, vecs[v].dat_kind);

        run_cmd("load_stall", 2'b00, 4'd0, 4'd6, 1'b0, 7, 8'hF9, 8'hFF, 0);
        run_cmd("store_stall", 2'b01, 4'd2, 4'd0, 1'b0, 7, 8'hFF, 8'hF5, 1);

        // Reset during beat 2 of a LOAD must kill the write select without a clock edge.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_src = 4'd0; cmd_dst = 4'd4; ld_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 chk("rst.beat1", int'(rf_sel_in_3), 4);
        @(negedge clk);
        #1 chk("rst.beat2", int'(rf_sel_in_3), 4);
        #1 rst = 1'b0;
        #1 chk("rst.async_sel", int'({rf_sel_in_1, rf_sel_in_3, rf_sel_out_1, rf_sel_out_3, rf_op}), 0);
        chk("rst.async_stat", int'({busy, ld_ready, done, err}), 0);
        @(negedge clk);
        rst = 1'b1; ld_valid = 1'b0;
        #1 chk("rst.release", int'({busy, cmd_ready}), 2'b01);
        run_cmd("load_after_rst", 2'b00, 4'd0, 4'd4, 1'b0, 5, 8'hFF, 8'hFF, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
